// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and baud divisor helper.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter emitting a one-cycle tick on every wrap from DIV-1 to 0.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// with valid/ack byte handshake and framing/overrun/parity error pulses.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  import uart_pkg::*;

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVS);
  localparam logic [3:0] SC_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] SC_LAST = 4'(OVS - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic sync1;
  logic rxs;
  logic tick;

  rx_state_t state, state_next;
  logic [3:0] sc, sc_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic capture;
  logic stop_bad;
`ifdef UART_RX_PARITY_EN
  logic par_flag, par_flag_next;
`endif

  // Idle-high reset keeps a spurious start bit from appearing after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_flag <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      sc      <= sc_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_flag <= par_flag_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    sc_next      = sc;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    capture      = 1'b0;
    stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_next = par_flag;
`endif
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state_next = ST_START;
            sc_next    = '0;
          end
        end
        ST_START: begin
          // Re-check at mid start bit so short glitches fall back to idle.
          if (sc == SC_MID) begin
            if (!rxs) begin
              state_next   = ST_DATA;
              sc_next      = '0;
              bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
              par_flag_next = 1'b0;
`endif
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            sc_next = sc + 4'd1;
          end
        end
        ST_DATA: begin
          sc_next = sc + 4'd1;
          if (sc == SC_LAST) begin
            shift_next   = {rxs, shift[DATA_BITS-1:1]};
            bit_idx_next = bit_idx + 3'd1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          sc_next = sc + 4'd1;
          if (sc == SC_LAST) begin
            if (rxs != (^shift)) begin
              par_flag_next = 1'b1;
            end
            state_next = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          sc_next = sc + 4'd1;
          if (sc == SC_LAST) begin
            state_next = ST_IDLE;
            if (rxs) begin
              capture = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // A capture coinciding with an ack wins and is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_bad;
      overrun   <= capture & rx_valid & ~rx_ack;
      rx_valid  <= capture | (rx_valid & ~rx_ack);
      if (capture) begin
        data_out <= shift;
      end
`ifdef UART_RX_PARITY_EN
      parity_err <= capture & par_flag;
`endif
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a frame-level model.
// Runs with a small clock so one bit is 64 clocks; honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 614_400;
  localparam int BAUD     = 9600;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = (CLK_FREQ / (BAUD * OVS)) * OVS;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_ack    (rx_ack),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observed event counts
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  int n_rise = 0;
  logic prev_valid = 1'b0;

  // Frame-level reference model
  int exp_data = 0;
  int exp_valid = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int exp_pe = 0;
  int exp_rise = 0;

  always @(negedge clk) begin
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_pe++;
`endif
    if (rx_valid && !prev_valid) n_rise++;
    prev_valid = rx_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/data"}, 32'(data_out), 32'(exp_data));
    checkOutput({tag, "/valid"}, 32'(rx_valid), 32'(exp_valid));
    checkOutput({tag, "/busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "/frame_err_cnt"}, 32'(n_fe), 32'(exp_fe));
    checkOutput({tag, "/overrun_cnt"}, 32'(n_ov), 32'(exp_ov));
    checkOutput({tag, "/capture_cnt"}, 32'(n_rise), 32'(exp_rise));
`ifdef UART_RX_PARITY_EN
    checkOutput({tag, "/parity_err_cnt"}, 32'(n_pe), 32'(exp_pe));
`endif
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame after gap idle clocks and updates the model with its effect.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_flip, input int gap);
    $display("[TB] frame data=%02h stop=%0d parity_flip=%0d gap=%0d", data, stop_bit, par_flip, gap);
    rx_in = 1'b1;
    waitClocks(gap);
    rx_in = 1'b0;
    waitClocks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      waitClocks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^data) ^ par_flip;
    waitClocks(BIT_CLKS);
`endif
    rx_in = stop_bit;
    waitClocks(BIT_CLKS);
    rx_in = 1'b1;
    if (stop_bit) begin
      if (exp_valid != 0) exp_ov++;
      else exp_rise++;
      exp_valid = 1;
      exp_data = int'(data);
`ifdef UART_RX_PARITY_EN
      if (par_flip) exp_pe++;
`endif
    end else begin
      exp_fe++;
      // let the receiver drop the spurious start seen on the low stop bit
      waitClocks(16);
    end
  endtask

  task automatic ackByte();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    exp_valid = 0;
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    rx_ack = 1'b0;
    waitClocks(3);
    checkOutput("reset/data", 32'(data_out), 32'h00);
    checkOutput("reset/valid", 32'(rx_valid), 32'd0);
    checkOutput("reset/frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset/overrun", 32'(overrun), 32'd0);
    checkOutput("reset/busy", 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    checkOutput("reset/parity_err", 32'(parity_err), 32'd0);
`endif
    rst = 1'b0;
    waitClocks(10);

    // Single byte and acknowledge
    applyStimulus(8'hAA, 1'b1, 1'b0, 20);
    checkAll("aa");
    ackByte();
    waitClocks(2);
    checkAll("aa_ack");
    ackByte();
    waitClocks(2);
    checkAll("idle_ack");

    // Reset during data bit 3 of 0xFF, then a clean frame
    rx_in = 1'b0;
    waitClocks(BIT_CLKS);
    rx_in = 1'b1;
    waitClocks(3 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 0;
    exp_valid = 0;
    checkOutput("midreset/busy", 32'(busy), 32'd0);
    waitClocks(6 * BIT_CLKS);
    checkAll("midreset");
    applyStimulus(8'h5A, 1'b1, 1'b0, 30);
    checkAll("after_reset_5a");
    ackByte();

    // Overrun on back-to-back frames without ack
    applyStimulus(8'hA5, 1'b1, 1'b0, 40);
    checkAll("ovr_first");
    applyStimulus(8'h3C, 1'b1, 1'b0, 0);
    checkAll("ovr_second");
    ackByte();

    // Framing error followed by a good frame
    applyStimulus(8'h81, 1'b0, 1'b0, 25);
    checkAll("framing");
    applyStimulus(8'h42, 1'b1, 1'b0, 100);
    checkAll("after_framing");
    ackByte();

    // Short glitch on the idle line
    waitClocks(100);
    rx_in = 1'b0;
    waitClocks(10);
    checkOutput("glitch/busy_high", 32'(busy), 32'd1);
    waitClocks(2);
    rx_in = 1'b1;
    waitClocks(36);
    checkOutput("glitch/busy_low", 32'(busy), 32'd0);
    waitClocks(2 * BIT_CLKS);
    checkAll("glitch");

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b1, 30);
    checkAll("parity_bad");
    ackByte();
`endif

    // Randomized frames
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      bit stop_ok;
      bit flip;
      int gap;
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      flip = 1'b0;
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`endif
      gap = int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) ackByte();
      applyStimulus(d, stop_ok, flip, gap);
      checkAll($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage, the consumer of the serial stream produced by the team's `tx` block. It synchronises the asynchronous `rx_in` line and oversamples it 16x. It recovers 8N1 frames, LSB first, and presents each byte on a parallel output with a valid/ack handshake. Framing and overrun errors are flagged, and parity checking is available as a compile-time option.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line bit rate.
- `OVS`, 16, oversampling factor; fixed at 16 by the sample-point rules below.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  reset; one clock, reset is asynchronous and active-high.
- `rx_in`  input  1  serial line; idle high; asynchronous to `clk`.
- `rx_ack`  input  1  consumer acknowledge; clears `rx_valid`.
- `data_out`  output  8  last received byte.
- `rx_valid`  output  1  level; high from byte capture until `rx_ack`.
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low.
- `overrun`  output  1  one-cycle pulse; new byte captured while `rx_valid` was still high.
- `parity_err`  output  1  one-cycle pulse; present only with `UART_RX_PARITY_EN`.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser**
  - `rx_in` passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses the synchronised value `rxs`.
- **Oversample tick generator**
  - Divisor `DIV = CLK_FREQ/(BAUD*OVS)`, integer-truncated; 651 at the defaults.
  - Produces a 1-cycle `tick` each time its counter wraps from `DIV-1` to 0.
  - The counter free-runs in all states.
- **FSM states:** IDLE, START, DATA, PARITY (built only with the macro), STOP.
- **IDLE**
  - On `rxs`==0 sampled on a tick: go to START and clear the 4-bit sub-bit counter `sc`.
- **START**
  - Count ticks; at `sc`==7 (mid start bit) re-sample the line.
  - If `rxs`==0: clear `sc` and the bit index, go to DATA.
  - If `rxs`==1: false start; return to IDLE, no outputs change.
- **DATA**
  - Every 16 ticks (`sc` wraps 15→0), sample `rxs` into the shift register MSB and shift right, so LSB arrives first.
  - A 3-bit index counts 0..7; after bit 7 go to PARITY if built, else STOP.
- **PARITY**
  - Sample once after 16 ticks.
  - Compare against even parity of the received data; a mismatch latches an internal flag.
- **STOP**
  - Sample after 16 ticks (mid stop bit).
  - `rxs`==1: capture the byte per the rules below; go to IDLE.
  - `rxs`==0: pulse `frame_err`; `data_out` and `rx_valid` unchanged; go to IDLE.
- **Byte capture** (on a good stop bit)
  - Load `data_out` and set `rx_valid`.
  - If `rx_valid` was already high and not being acked that cycle, pulse `overrun`; the new byte overwrites `data_out`.
  - With the macro, pulse `parity_err` in the same cycle if the parity flag is set; the byte is still delivered.
- **Back-to-back frames:** returning to IDLE at mid stop bit allows a start bit immediately following the stop bit to be detected.

## Timing
- **Reset values:** `data_out`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, `busy`=0; FSM=IDLE; all counters 0.
- **Reset mid-frame:** the partial frame is discarded; no pulses are produced.
- **Receive latency:**
  - The falling edge on `rx_in` is visible on `rxs` after 2 clocks.
  - Start is detected on the next tick (≤ DIV clocks later).
  - `rx_valid` rises 1 clock after the stop-bit mid-sample tick, about 9.5 bit times after the start edge (~990 µs at 9600 baud).
- **Handshake**
  - `rx_ack` high for one cycle while `rx_valid`=1 clears `rx_valid` on the next edge.
  - `rx_ack` while `rx_valid`=0 is ignored.
  - Capture and ack in the same cycle: capture wins (`rx_valid` stays 1), and no overrun is signalled.
- **Error pulses** are exactly one `clk` wide.
- **Glitches:** a low pulse shorter than half a bit is rejected by the START re-check.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** frame is 8E1. The PARITY state, the `parity_err` port and the parity check are built; STOP is sampled 16 ticks after the parity bit.
- **Undefined:** frame is 8N1. There is no PARITY state and no `parity_err` port; STOP follows data bit 7.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state typedef.
  - `OVS`=16 and `MID_SAMPLE`=7.
  - `DATA_BITS`=8.
  - Divisor function `baud_div(clk_freq, baud, ovs)`, shared with `tx`.
- **Sub-module `uart_baud_tick`:** parameterised divisor counter producing `tick`; reusable by `tx`.

## Test plan
- **Byte 0xAA, 8N1, 9600 baud:** drive 0xAA on `rx_in` at 104.167 µs per bit → `data_out`=0xAA, `rx_valid`=1, no error pulses; `rx_ack` then clears `rx_valid`.
- **Reset mid-frame:** `rst` asserted during data bit 3 of 0xFF, then a clean 0x5A → outputs hold reset values throughout; later `data_out`=0x5A and exactly one capture.
- **Overrun:** send 0xA5 then 0x3C back-to-back with no `rx_ack` → one `overrun` pulse at the second capture; `data_out`=0x3C, `rx_valid`=1.
- **Framing error:** send 0x81 with the stop bit held low → `frame_err` pulses once; `rx_valid` stays 0, `data_out` unchanged; the next good frame 0x42 is received.
- **False start:** a 20 µs low glitch on the idle line → FSM returns to IDLE; `busy` falls before mid bit, and there is no capture and no error.
- **Parity (with `UART_RX_PARITY_EN`):** send 0x07 with the parity bit set to 0 (wrong for even parity) → `parity_err` pulse alongside `rx_valid`; `data_out`=0x07.
